stage_seq_ctrl: RTL
===================

# stage_seq_ctrl

Parametrised sequencer for the audio-compress processing chain. It generalises the fixed MDCT→QUAN→IQUAN→IMDCT controller to NUM_STAGES stages with a per-run stage bypass mask, a configurable inter-stage gap, and a per-stage timeout with error reporting. It sits between the system register/interrupt interface and the per-stage engines: it drives each engine's reset release and start pulse, and waits for that engine's finish signal.

## Interface
Parameters:
- NUM_STAGES, 4, number of sequenced stages; stage 0 runs first (≥1)
- ADDR_W, 19, width of the music start address
- GAP_CYCLES, 2, idle cycles after reset release and between stages (≥1)
- TIMEOUT_W, 16, width of the timeout counter and limit

Ports:
- clk_in  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start_sys  in  1  run request, sampled only in IDLE
- intr_clr_sys  in  1  clears intr_sys, err_timeout and err_stage
- stage_en  in  NUM_STAGES  stage enable mask, latched when a start is accepted
- timeout_limit  in  TIMEOUT_W  WAIT-cycle limit per stage; 0 disables the timeout
- start_music_addr  in  ADDR_W  music start address
- start_music_addr_r  out  ADDR_W  address latched when a start is accepted
- start_clr_sys  out  1  one-cycle acknowledge of an accepted start
- intr_sys  out  1  sticky run-complete interrupt
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  sticky: the last run aborted on a timeout
- err_stage  out  NUM_STAGES  one-hot index of the stage that timed out (sticky)
- rstn_stage  out  NUM_STAGES  active-low reset to each stage engine
- start_stage  out  NUM_STAGES  one-cycle start pulse to each stage engine
- finish_stage  in  NUM_STAGES  completion pulse or level from each stage engine

## Operation
- All outputs are registered.
- Reset values: all outputs 0; rstn_stage = 0, which holds every engine in reset; state = IDLE.
- State machine: IDLE → ARM → START → WAIT → (GAP → START)* → DONE → IDLE.
- IDLE:
  - rstn_stage = 0, start_stage = 0.
  - If start_sys = 1, accept the start: pulse start_clr_sys, latch stage_en and start_music_addr, clear intr_sys, err_timeout and err_stage, then go to ARM.
- ARM:
  - rstn_stage = latched mask; disabled stages stay in reset.
  - Hold for GAP_CYCLES cycles, then go to START with idx = lowest enabled stage.
  - If the mask is 0, go to DONE instead.
- START: start_stage[idx] = 1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - finish_stage[idx] is sampled here only. Finish bits of other stages, and any finish asserted during START, are ignored.
  - On finish: go to GAP if a higher enabled stage exists (idx = next enabled stage), otherwise go to DONE.
  - The timeout counter increments every WAIT cycle. If timeout_limit ≠ 0 and the count reaches timeout_limit without finish, set err_timeout = 1 and err_stage = onehot(idx), then go to DONE. The remaining stages are skipped.
  - Finish and timeout in the same cycle: finish wins.
- GAP: hold for GAP_CYCLES cycles, then go to START.
- DONE: set intr_sys = 1, then go to IDLE on the next edge.
- intr_sys, err_timeout and err_stage hold until intr_clr_sys = 1 or the next accepted start.
  - If intr_clr_sys is asserted in the same cycle as DONE's set, the set wins.
- intr_clr_sys has no effect on sequencing. start_sys outside IDLE is ignored.
- Asynchronous reset mid-run returns the block to IDLE with all outputs 0. No interrupt is raised.
- The timeout counter saturates and does not wrap.

## Timing
- Edge 0: start_sys seen in IDLE.
- Cycle 1: start_clr_sys = 1, busy = 1, rstn_stage = mask.
- Cycles 1..GAP_CYCLES: ARM.
- Cycle GAP_CYCLES+1: start_stage[first] = 1.
- The first WAIT cycle follows the START cycle. Finish sampled in WAIT cycle k causes:
  - GAP during cycles k+1 .. k+GAP_CYCLES, and the next start pulse in cycle k+GAP_CYCLES+1; or
  - DONE in cycle k+1, intr_sys = 1 from cycle k+2, and IDLE (busy = 0) in cycle k+2.
- Timeout: with limit L, the L-th WAIT cycle without finish raises the error; DONE follows in the next cycle.
- Minimum run, GAP_CYCLES = 1, one stage, finish in the first WAIT cycle: intr_sys rises 5 cycles after start_sys is sampled.

## Test plan
- Full run, NUM_STAGES = 4, GAP_CYCLES = 2, mask = 4'b1111, each finish 3 cycles after its start -> pulses on start_stage[0..3] in order, spaced 6 cycles apart; intr_sys = 1, err_timeout = 0; rstn_stage = 4'b1111 during the run and 0 after.
- Bypass, mask = 4'b1010 -> only start_stage[1] and start_stage[3] pulse; rstn_stage = 4'b1010; stages 0 and 2 stay in reset.
- Timeout, timeout_limit = 5, stage 2 never finishes -> err_timeout = 1, err_stage = 4'b0100; start_stage[3] never pulses; intr_sys = 1; intr_clr_sys then clears all three flags.
- Spurious and early finishes: finish_stage[3] held high throughout, finish_stage[0] asserted during START -> both are ignored; stage 0 completes only on a WAIT-cycle finish.
- Reset mid-run: rst_n low during stage 1 WAIT -> all outputs 0 immediately; a following start_sys = 1 runs a clean sequence from stage 0.
- Mask = 0 with start_sys -> start_clr_sys pulse, ARM, DONE; intr_sys = 1 with no start pulses. A second start_sys while busy is ignored.

Source files
------------

// File: rtl/stage_seq_ctrl.sv
// stage_seq_ctrl
//   Sequences NUM_STAGES processing engines (stage 0 first). On an accepted start it
//   releases the enabled engines from reset, then for each enabled stage issues a one-cycle
//   start pulse and waits for that stage's finish, with a configurable gap between steps
//   and an optional per-stage timeout. Completion raises a sticky interrupt.
//
// Ports
//   clk_in, rst_n        clock, asynchronous active-low reset
//   start_sys            run request (sampled only while idle)
//   intr_clr_sys         clears intr_sys / err_timeout / err_stage
//   stage_en             stage enable mask, latched on start
//   timeout_limit        WAIT-cycle limit per stage, 0 = no timeout
//   start_music_addr     music start address, latched on start (start_music_addr_r)
//   start_clr_sys        one-cycle start acknowledge
//   intr_sys             sticky run-complete interrupt
//   busy                 high whenever not idle
//   err_timeout          sticky timeout flag; err_stage holds the one-hot stage
//   rstn_stage           active-low reset per engine
//   start_stage          one-cycle start pulse per engine
//   finish_stage         completion signal per engine
module stage_seq_ctrl #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  start_sys,
  input  logic                  intr_clr_sys,
  input  logic [NUM_STAGES-1:0] stage_en,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  input  logic [ADDR_W-1:0]     start_music_addr,
  output logic [ADDR_W-1:0]     start_music_addr_r,
  output logic                  start_clr_sys,
  output logic                  intr_sys,
  output logic                  busy,
  output logic                  err_timeout,
  output logic [NUM_STAGES-1:0] err_stage,
  output logic [NUM_STAGES-1:0] rstn_stage,
  output logic [NUM_STAGES-1:0] start_stage,
  input  logic [NUM_STAGES-1:0] finish_stage
);

  localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GapLast = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StArm, StStart, StWait, StGap, StDone} state_e;

  // Lowest enabled stage at or above 'from'; returns {found, index}.
  function automatic logic [IDX_W:0] find_en(input logic [NUM_STAGES-1:0] mask,
                                             input int from);
    logic             found;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
    return {found, idx};
  endfunction

  state_e                r_state, w_state_d;
  logic [IDX_W-1:0]      r_idx, w_idx_d;
  logic [NUM_STAGES-1:0] r_mask, w_mask_d;
  logic [ADDR_W-1:0]     r_addr, w_addr_d;
  logic [GAP_W-1:0]      r_gap, w_gap_d;
  logic [TIMEOUT_W-1:0]  r_to, w_to_d, w_to_inc;
  logic                  r_start_clr, w_start_clr_d;
  logic                  r_intr, w_intr_d;
  logic                  r_busy, w_busy_d;
  logic                  r_err, w_err_d;
  logic [NUM_STAGES-1:0] r_err_stage, w_err_stage_d;
  logic [NUM_STAGES-1:0] r_rstn, w_rstn_d;
  logic [NUM_STAGES-1:0] r_start, w_start_d;
  logic                  w_accept, w_set_done, w_set_err;
  logic [IDX_W:0]        w_first, w_next;

  assign w_first = find_en(r_mask, 0);
  assign w_next  = find_en(r_mask, int'(r_idx) + 1);

  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_mask_d   = r_mask;
    w_addr_d   = r_addr;
    w_gap_d    = r_gap;
    w_to_d     = r_to;
    w_accept   = 1'b0;
    w_set_done = 1'b0;
    w_set_err  = 1'b0;
    // Saturating increment so a long wait never wraps past the limit.
    w_to_inc   = (r_to == '1) ? r_to : r_to + 1'b1;

    case (r_state)
      StIdle: begin
        if (start_sys) begin
          w_accept  = 1'b1;
          w_mask_d  = stage_en;
          w_addr_d  = start_music_addr;
          w_gap_d   = '0;
          w_state_d = StArm;
        end
      end
      StArm: begin
        if (r_gap == GapLast) begin
          if (w_first[IDX_W]) begin
            w_idx_d   = w_first[IDX_W-1:0];
            w_state_d = StStart;
          end else begin
            w_state_d = StDone;
          end
        end else begin
          w_gap_d = r_gap + 1'b1;
        end
      end
      StStart: begin
        w_to_d    = '0;
        w_state_d = StWait;
      end
      StWait: begin
        w_to_d = w_to_inc;
        // Finish is checked first so it wins over a same-cycle timeout.
        if (finish_stage[r_idx]) begin
          if (w_next[IDX_W]) begin
            w_idx_d   = w_next[IDX_W-1:0];
            w_gap_d   = '0;
            w_state_d = StGap;
          end else begin
            w_state_d = StDone;
          end
        end else if (timeout_limit != '0 && w_to_inc >= timeout_limit) begin
          w_set_err = 1'b1;
          w_state_d = StDone;
        end
      end
      StGap: begin
        if (r_gap == GapLast) w_state_d = StStart;
        else                  w_gap_d   = r_gap + 1'b1;
      end
      StDone: begin
        w_set_done = 1'b1;
        w_state_d  = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    // Sticky flags: clear first so a same-cycle set takes priority.
    w_intr_d      = r_intr;
    w_err_d       = r_err;
    w_err_stage_d = r_err_stage;
    if (intr_clr_sys || w_accept) begin
      w_intr_d      = 1'b0;
      w_err_d       = 1'b0;
      w_err_stage_d = '0;
    end
    if (w_set_done) w_intr_d = 1'b1;
    if (w_set_err) begin
      w_err_d       = 1'b1;
      w_err_stage_d = NUM_STAGES'(1) << r_idx;
    end

    w_start_clr_d = w_accept;
    w_busy_d      = (w_state_d != StIdle);
    w_rstn_d      = w_busy_d ? w_mask_d : '0;
    w_start_d     = (w_state_d == StStart) ? (NUM_STAGES'(1) << w_idx_d) : '0;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_mask      <= '0;
      r_addr      <= '0;
      r_gap       <= '0;
      r_to        <= '0;
      r_start_clr <= 1'b0;
      r_intr      <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_err_stage <= '0;
      r_rstn      <= '0;
      r_start     <= '0;
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx_d;
      r_mask      <= w_mask_d;
      r_addr      <= w_addr_d;
      r_gap       <= w_gap_d;
      r_to        <= w_to_d;
      r_start_clr <= w_start_clr_d;
      r_intr      <= w_intr_d;
      r_busy      <= w_busy_d;
      r_err       <= w_err_d;
      r_err_stage <= w_err_stage_d;
      r_rstn      <= w_rstn_d;
      r_start     <= w_start_d;
    end
  end

  assign start_music_addr_r = r_addr;
  assign start_clr_sys      = r_start_clr;
  assign intr_sys           = r_intr;
  assign busy               = r_busy;
  assign err_timeout        = r_err;
  assign err_stage          = r_err_stage;
  assign rstn_stage         = r_rstn;
  assign start_stage        = r_start;

endmodule
